// File: rtl/pid_pkg.sv
// Shared types and arithmetic helpers for the multi-channel PID controller.
package pid_pkg;

    // Gains are held at a fixed container width; numerators are sign-extended
    // and shift amounts zero-extended into it, so W <= 32 and SHW <= 8.
    localparam int GAIN_NW  = 32;
    localparam int GAIN_SHW = 8;

    typedef struct packed {
        logic signed [GAIN_NW-1:0]  n;
        logic        [GAIN_SHW-1:0] sh;
    } gain_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P,
        S_I,
        S_D,
        S_OUT
    } state_t;

    // Saturate a signed value to the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Clamp a signed value to [-lim, +lim]; lim is expected to be non-negative.
    function automatic logic signed [63:0] clamp_s(input logic signed [63:0] x,
                                                   input logic signed [63:0] lim);
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

endpackage

// File: rtl/pid_mc_if.sv
// Sample/result handshake bundle between sensor front-end, PID block and actuators.
interface pid_mc_if #(
    parameter int W   = 16,
    parameter int CH  = 4,
    parameter int SHW = 5
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [CW-1:0]        in_ch;
    logic signed [W-1:0]  setpoint;
    logic signed [W-1:0]  observed;
    logic signed [W-1:0]  kp_n;
    logic signed [W-1:0]  ki_n;
    logic signed [W-1:0]  kd_n;
    logic [SHW-1:0]       kp_sh;
    logic [SHW-1:0]       ki_sh;
    logic [SHW-1:0]       kd_sh;
    logic signed [W-1:0]  max_integral;
    logic [W-1:0]         deriv_ds;
    logic                 clr_valid;
    logic [CW-1:0]        clr_ch;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        out_ch;
    logic signed [W-1:0]  out;

    modport master (
        output in_valid, in_ch, setpoint, observed, kp_n, ki_n, kd_n,
               kp_sh, ki_sh, kd_sh, max_integral, deriv_ds, clr_valid, clr_ch, out_ready,
        input  in_ready, out_valid, out_ch, out
    );

    modport slave (
        input  in_valid, in_ch, setpoint, observed, kp_n, ki_n, kd_n,
               kp_sh, ki_sh, kd_sh, max_integral, deriv_ds, clr_valid, clr_ch, out_ready,
        output in_ready, out_valid, out_ch, out
    );
endinterface

// File: rtl/sat_mul_shift.sv
// Shared multiplier path: term = sat_W((x * k_n) >>> k_sh).
// The numerator is a sign-extended W-bit value, so the wider product is
// numerically identical to the 2W-bit product.
module sat_mul_shift
    import pid_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0]       x,
    input  logic signed [GAIN_NW-1:0] k_n,
    input  logic [GAIN_SHW-1:0]       k_sh,
    output logic signed [W-1:0]       term
);
    localparam int PW = W + GAIN_NW;

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;

    assign w_prod  = PW'(x) * PW'(k_n);
    assign w_shift = w_prod >>> k_sh;
    assign term    = W'(sat_s(64'(w_shift), W));

endmodule

// File: rtl/pid_mc.sv
// Time-multiplexed multi-channel PID: one multiplier evaluates P, I, D in
// consecutive cycles; per-channel integral/derivative state is committed at accept.
module pid_mc
    import pid_pkg::*;
#(
    parameter int W   = 16,
    parameter int CH  = 4,
    parameter int SHW = 5
) (
    input  logic   clk,
    input  logic   rst,
    pid_mc_if.slave bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    state_t r_state, w_state_next;
    logic   w_accept, w_clear;

    // Per-channel state exposed for selection by the incoming channel index
    logic signed [W-1:0] w_int_arr    [CH];
    logic signed [W-1:0] w_old_arr    [CH];
    logic signed [W-1:0] w_der_arr    [CH];
    logic [W-1:0]        w_cnt_arr    [CH];
    logic                w_primed_arr [CH];

    logic signed [W:0]   w_diff, w_isum, w_dsub;
    logic signed [W-1:0] w_err, w_imax, w_int_new, w_der_new, w_old_new;
    logic [W-1:0]        w_cnt_new;

    // In-flight sample
    logic [CW-1:0]       r_ch;
    gain_t               r_kp, r_ki, r_kd;
    logic signed [W-1:0] r_err, r_int, r_der;
    logic signed [W+1:0] r_acc;
    logic signed [W-1:0] r_out;
    logic [CW-1:0]       r_out_ch;

    logic signed [W-1:0] w_x, w_term;
    gain_t               w_gain;
    logic signed [W+1:0] w_sum;

    assign bus.in_ready  = (r_state == S_IDLE) && !bus.clr_valid && !rst;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_clear       = (r_state == S_IDLE) && bus.clr_valid;
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out       = r_out;
    assign bus.out_ch    = r_out_ch;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state: accept -> P -> I -> D -> OUT, leave OUT on the result handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_P;
            S_P:     w_state_next = S_I;
            S_I:     w_state_next = S_D;
            S_D:     w_state_next = S_OUT;
            S_OUT:   if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Error, anti-windup integral and downsampled derivative for the incoming channel
    always_comb begin
        w_diff    = (W+1)'(bus.setpoint) - (W+1)'(bus.observed);
        w_err     = W'(sat_s(64'(w_diff), W));
        w_imax    = bus.max_integral[W-1] ? '0 : bus.max_integral;
        w_isum    = (W+1)'(w_int_arr[bus.in_ch]) + (W+1)'(w_err);
        w_int_new = W'(clamp_s(64'(w_isum), 64'(w_imax)));
        w_dsub    = (W+1)'(w_err) - (W+1)'(w_old_arr[bus.in_ch]);
        w_der_new = w_der_arr[bus.in_ch];
        w_old_new = w_old_arr[bus.in_ch];
        w_cnt_new = w_cnt_arr[bus.in_ch] + W'(1);
        if (!w_primed_arr[bus.in_ch]) begin
            w_der_new = '0;
            w_old_new = w_err;
            w_cnt_new = '0;
        end else if (w_cnt_arr[bus.in_ch] == bus.deriv_ds) begin
            w_der_new = W'(sat_s(64'(w_dsub), W));
            w_old_new = w_err;
            w_cnt_new = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            localparam logic [CW-1:0] IDX = CW'(gi);
            logic signed [W-1:0] r_integral, r_old_err, r_deriv;
            logic [W-1:0]        r_cnt;
            logic                r_primed;

            // Channel state: zeroed by reset or clear, committed on accept
            always_ff @(posedge clk) begin
                if (rst || (w_clear && bus.clr_ch == IDX)) begin
                    r_integral <= '0;
                    r_old_err  <= '0;
                    r_deriv    <= '0;
                    r_cnt      <= '0;
                    r_primed   <= 1'b0;
                end else if (w_accept && bus.in_ch == IDX) begin
                    r_integral <= w_int_new;
                    r_old_err  <= w_old_new;
                    r_deriv    <= w_der_new;
                    r_cnt      <= w_cnt_new;
                    r_primed   <= 1'b1;
                end
            end

            assign w_int_arr[gi]    = r_integral;
            assign w_old_arr[gi]    = r_old_err;
            assign w_der_arr[gi]    = r_deriv;
            assign w_cnt_arr[gi]    = r_cnt;
            assign w_primed_arr[gi] = r_primed;
        end
    endgenerate

    // Operand select for the shared multiplier
    always_comb begin
        w_x    = r_der;
        w_gain = r_kd;
        case (r_state)
            S_P: begin w_x = r_err; w_gain = r_kp; end
            S_I: begin w_x = r_int; w_gain = r_ki; end
            default: ;
        endcase
    end

    sat_mul_shift #(.W(W)) u_mul (
        .x    (w_x),
        .k_n  (w_gain.n),
        .k_sh (w_gain.sh),
        .term (w_term)
    );

    // Extra headroom bits keep the three-term sum from wrapping before saturation
    assign w_sum = r_acc + (W+2)'(w_term);

    // Latch the sample at accept, accumulate terms, register the saturated result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch     <= '0;
            r_kp     <= '0;
            r_ki     <= '0;
            r_kd     <= '0;
            r_err    <= '0;
            r_int    <= '0;
            r_der    <= '0;
            r_acc    <= '0;
            r_out    <= '0;
            r_out_ch <= '0;
        end else begin
            if (w_accept) begin
                r_ch  <= bus.in_ch;
                r_kp  <= gain_t'{n: GAIN_NW'(bus.kp_n), sh: GAIN_SHW'(bus.kp_sh[SHW-1:0])};
                r_ki  <= gain_t'{n: GAIN_NW'(bus.ki_n), sh: GAIN_SHW'(bus.ki_sh[SHW-1:0])};
                r_kd  <= gain_t'{n: GAIN_NW'(bus.kd_n), sh: GAIN_SHW'(bus.kd_sh[SHW-1:0])};
                r_err <= w_err;
                r_int <= w_int_new;
                r_der <= w_der_new;
            end
            case (r_state)
                S_P: r_acc <= (W+2)'(w_term);
                S_I: r_acc <= w_sum;
                S_D: begin
                    r_out    <= W'(sat_s(64'(w_sum), W));
                    r_out_ch <= r_ch;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_mc.sv
// Directed bench for pid_mc: hand-computed expected outputs per sample.
module tb_pid_mc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pid_mc_if #(.W(16), .CH(4), .SHW(5)) bus ();

    pid_mc #(.W(16), .CH(4), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic set_gains(input int kp, input int kps, input int ki, input int kis,
                             input int kd, input int kds, input int imax, input int ds);
        bus.kp_n = 16'(kp);  bus.kp_sh = 5'(kps);
        bus.ki_n = 16'(ki);  bus.ki_sh = 5'(kis);
        bus.kd_n = 16'(kd);  bus.kd_sh = 5'(kds);
        bus.max_integral = 16'(imax);
        bus.deriv_ds = 16'(ds);
    endtask

    // One sample: accept, check latency/out/out_ch, optional backpressure, handshake.
    task automatic run_sample(input string tag, input int ch, input int sp, input int obs,
                              input int expv, input int hold);
        int n;
        int lat;
        logic signed [15:0] saved_kp;
        @(negedge clk);
        bus.in_ch     = 2'(ch);
        bus.setpoint  = 16'(sp);
        bus.observed  = 16'(obs);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "/ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        saved_kp     = bus.kp_n;
        bus.setpoint = 16'($urandom);
        bus.observed = 16'($urandom);
        bus.kp_n     = 16'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 20);
        check({tag, "/lat"}, lat, 4);
        check({tag, "/out"}, bus.out, expv);
        check({tag, "/ch"}, bus.out_ch, ch);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, "/hold_out"}, bus.out, expv);
            check({tag, "/hold_valid"}, bus.out_valid, 1);
            check({tag, "/hold_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.kp_n      = saved_kp;
        check({tag, "/ready_after"}, bus.in_ready, 1);
        $display("sample %s ch=%0d sp=%0d obs=%0d out=%0d exp=%0d lat=%0d",
                 tag, ch, sp, obs, bus.out, expv, lat);
    endtask

    task automatic do_clear(input int ch);
        @(negedge clk);
        bus.clr_valid = 1'b1;
        bus.clr_ch    = 2'(ch);
        @(negedge clk);
        bus.clr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.setpoint = '0; bus.observed = '0;
        bus.clr_valid = 1'b0; bus.clr_ch = '0; bus.out_ready = 1'b0;
        set_gains(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst/in_ready", bus.in_ready, 0);
        check("rst/out_valid", bus.out_valid, 0);
        check("rst/out", bus.out, 0);
        check("rst/out_ch", bus.out_ch, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst/ready_after", bus.in_ready, 1);
        $display("reset released in_ready=%0d out_valid=%0d", bus.in_ready, bus.out_valid);

        // P only with backpressure, then arithmetic-shift floor
        set_gains(3, 1, 0, 0, 0, 0, 0, 0);
        run_sample("p_only", 2, 100, 40, 90, 3);
        set_gains(1, 1, 0, 0, 0, 0, 0, 0);
        run_sample("p_floor", 3, 0, 3, -2, 0);

        // Anti-windup and channel isolation
        set_gains(0, 0, 1, 0, 0, 0, 50, 0);
        run_sample("iw1", 0, 30, 0, 30, 0);
        run_sample("iw2", 0, 30, 0, 50, 0);
        run_sample("iw3", 0, 30, 0, 50, 0);
        run_sample("iso", 1, 5, 0, 5, 0);
        set_gains(0, 0, 1, 0, 0, 0, -7, 0);
        run_sample("neg_imax", 1, 5, 0, 0, 0);

        // Clear wins over a simultaneous sample
        set_gains(0, 0, 1, 0, 0, 0, 50, 0);
        @(negedge clk);
        bus.clr_valid = 1'b1; bus.clr_ch = 2'd0;
        bus.in_valid = 1'b1; bus.in_ch = 2'd0; bus.setpoint = 16'sd30; bus.observed = 16'sd0;
        #1;
        check("clr/in_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.clr_valid = 1'b0;
        bus.in_valid  = 1'b0;
        repeat (4) @(negedge clk);
        check("clr/no_accept", bus.out_valid, 0);
        $display("clear+valid ch=0 out_valid=%0d", bus.out_valid);
        run_sample("clr_restart", 0, 30, 0, 30, 0);

        // Derivative downsample on a freshly cleared channel
        do_clear(0);
        set_gains(0, 0, 0, 0, 1, 0, 0, 1);
        run_sample("d1", 0, 10, 0, 0, 0);
        run_sample("d2", 0, 20, 0, 0, 0);
        run_sample("d3", 0, 40, 0, 30, 0);
        run_sample("d4", 0, 80, 0, 30, 0);

        // Saturation
        set_gains(2, 0, 0, 0, 0, 0, 0, 0);
        run_sample("sat_pos", 3, 32767, -32768, 32767, 0);
        run_sample("sat_neg", 3, -32768, 32767, -32768, 0);
        set_gains(2, 0, 2, 0, 2, 0, 32767, 0);
        run_sample("sat3_pos", 2, 32767, -32768, 32767, 0);
        run_sample("sat3_neg", 2, -32768, 32767, -32768, 0);

        // Reset mid-sample discards the result
        set_gains(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.setpoint = 16'sd9; bus.observed = 16'sd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort/out_valid", bus.out_valid, 0);
        check("abort/in_ready", bus.in_ready, 1);
        $display("abort out_valid=%0d in_ready=%0d", bus.out_valid, bus.in_ready);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pid_mc.md
# pid_mc

Multi-channel, time-multiplexed PID controller. It replaces the single-channel 16-bit PID with parametrised data width and channel count, and one shared saturating multiplier reused over three cycles. Samples are accepted over a valid/ready handshake, and results are returned the same way. The block sits between the sensor front-end (setpoint/observed per channel) and the actuator drivers. Per-channel integral, derivative, priming and downsample state live inside the block.

## Interface
- W, 16: data and gain width (signed)
- CH, 4: number of channels
- SHW, 5: width of gain shift amounts (unsigned)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid / in_ready  in / out  1  sample handshake
- in_ch  in  $clog2(CH)  channel of sample
- setpoint, observed  in  W  signed sample
- kp_n, ki_n, kd_n  in  W  signed gain numerators
- kp_sh, ki_sh, kd_sh  in  SHW  gain right-shift amounts
- max_integral  in  W  integral clamp magnitude; negative values are treated as 0
- deriv_ds  in  W  derivative downsample count, unsigned
- clr_valid  in  1  clear state of channel clr_ch
- clr_ch  in  $clog2(CH)  channel to clear
- out_valid / out_ready  out / in  1  result handshake
- out_ch  out  $clog2(CH)  channel of result
- out  out  W  signed control output

## Operation
- FSM states and transitions:
  - IDLE: goes to P on accept.
  - P → I → D → OUT, one cycle each.
  - OUT: goes to IDLE when out_ready is high.
- in_ready = (state == IDLE) && !clr_valid.
- At the accept edge:
  - Latch channel, gains, shifts, max_integral and deriv_ds.
  - Commit channel state updates.
- error = sat_W(setpoint − observed), computed at W+1 bits.
- Integral: integral[ch] ← clamp(integral + error, −imax, +imax), computed at W+1 bits. The updated value is used for the I term.
- Derivative, per channel: primed bit, counter cnt, old_error, held derivative.
  - Unprimed: old_error ← error, derivative ← 0, cnt ← 0, primed ← 1.
  - Primed and cnt == deriv_ds: derivative ← sat_W(error − old_error), old_error ← error, cnt ← 0.
  - Otherwise: cnt ← cnt + 1, derivative held.
- Term = sat_W((x · k_n) >>> k_sh).
  - Product is 2W bits.
  - Shift is arithmetic (floors toward −∞).
- Terms are accumulated at W+2 bits; out = sat_W(P + I + D).
- Clear:
  - clr_valid is honoured only in IDLE.
  - It zeroes integral, cnt, derivative and old_error, and clears the primed bit of clr_ch.
  - It blocks acceptance that cycle (clear wins over a simultaneous in_valid).
  - In any other state, clr_valid is ignored.

## Timing
- Reset values:
  - state IDLE, out_valid 0, out 0, out_ch 0.
  - All channel state zero and unprimed.
  - in_ready is 0 while rst is high and 1 on the first cycle after.
- Latency: accept edge in cycle t; out_valid rises in cycle t+4.
- out and out_ch are registered and stable while out_valid && !out_ready.
- in_ready returns the cycle after the out handshake, giving a best-case throughput of 1 sample per 5 cycles.
- Input and gain changes after accept have no effect on the in-flight result.
- rst during any state aborts the sample: the result is discarded and no handshake completes.

## Structure
- pid_pkg holds:
  - a typedef for the gain bundle (struct: n, sh).
  - the FSM state enum.
  - sat/clamp functions parametrised by width.
- Sub-module sat_mul_shift (x, k_n, k_sh → sat_W term) is the single shared multiplier path.
- Per-channel state is held in register arrays indexed by channel (CH is small; no RAM).

## Test plan
- Reset: assert rst 3 cycles, then release → out_valid 0, out 0; in_ready 1 from the first cycle after release.
- P only, ch 2: kp=3/sh1, ki_n=kd_n=0, sp=100, obs=40 → out=90, out_ch=2, 4 cycles after accept. Shift floor check: error −3, kp=1/sh1 → out −2.
- Anti-windup:
  - ki=1/sh0, kp=kd=0, imax=50, error 30 three times on ch 0 → outputs 30, 50, 50.
  - Then ch 1 with error 5 → 5, showing channel isolation.
- Derivative downsample: kd=1/sh0, kp=ki=0, ds=1, errors 10, 20, 40, 80 on ch 0 → outputs 0, 0, 30, 30.
- Saturation:
  - sp=32767, obs=−32768, kp=2 → out 32767.
  - sp=−32768, obs=32767 → out −32768.
  - Three saturating terms summed → clamped, with no wrap.
- Backpressure and clear:
  - Hold out_ready low for 3 cycles in OUT → out stable, in_ready 0.
  - Assert clr_valid and in_valid together in IDLE → clear wins, no accept.
  - Next sample on the cleared channel re-primes, integral restarts at error.
